// File: rtl/rx_sup_pkg.sv
// rx_sup_pkg: shared definitions for the rx_sync_supervisor block.
// State encoding is fixed because state_dbg exports it to status registers.
package rx_sup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_WAIT  = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAIL      = 3'd5
    } sup_state_t;

    localparam int RETRY_W     = 4;
    localparam int RESYNC_W    = 8;
    localparam int ERR_TOTAL_W = 16;

    // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rx_err_window.sv
// rx_err_window: fixed-length observation window with a code-error counter.
// While active_i is high the window counter free-runs 0..ERR_WINDOW-1 and
// errors are tallied. limit_hit_o is raised on the very cycle the tally would
// reach ERR_LIMIT so the caller can leave LOCKED on that edge. An error on the
// window-end cycle is carried into the next window rather than the current one.
module rx_err_window
    import rx_sup_pkg::*;
#(
    parameter int ERR_WINDOW = 1024,
    parameter int ERR_LIMIT  = 8
) (
    input  logic wclk,
    input  logic RST,
    input  logic active_i,
    input  logic code_err_i,
    output logic limit_hit_o
);

    localparam int WIN_W = cnt_w(ERR_WINDOW);
    localparam int ERR_W = cnt_w(ERR_LIMIT + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ERR_WINDOW - 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);
    localparam logic [ERR_W-1:0] ERR_FULL = ERR_W'(ERR_LIMIT);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             win_end;

    assign win_end = (win_cnt_q == WIN_LAST);

    // Limit strobe: a window-end error only counts toward the next window.
    always_comb begin
        limit_hit_o = 1'b0;
        if (active_i && code_err_i) begin
            if (win_end) begin
                limit_hit_o = (ERR_LIMIT == 1);
            end else begin
                limit_hit_o = (err_cnt_q == ERR_LAST);
            end
        end
    end

    // Next window/error counts; both held at zero while inactive.
    always_comb begin
        win_cnt_d = win_cnt_q;
        err_cnt_d = err_cnt_q;
        if (!active_i) begin
            win_cnt_d = '0;
            err_cnt_d = '0;
        end else if (win_end) begin
            win_cnt_d = '0;
            err_cnt_d = code_err_i ? ERR_ONE : '0;
        end else begin
            win_cnt_d = win_cnt_q + WIN_ONE;
            if (code_err_i && (err_cnt_q != ERR_FULL)) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge wclk) begin
        if (RST) begin
            win_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: rtl/rx_sync_supervisor.sv
// rx_sync_supervisor: per-channel link supervisor for the FE-I4 receive path.
// Drives rec_sync reset, bounds the wait for word alignment, retries a bounded
// number of times, and re-arms alignment on loss of sync/lock or a burst of
// decoder code errors. All outputs are registered from the next state.
// Build option: define RX_SUP_STATS_EN to implement resync_count/err_total;
// otherwise both read 0 and no counter logic exists. The FSM is the same.
module rx_sync_supervisor
    import rx_sup_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int SYNC_TIMEOUT = 4096,
    parameter int ERR_WINDOW   = 1024,
    parameter int ERR_LIMIT    = 8,
    parameter int MAX_RETRY    = 15
) (
    input  logic        wclk,
    input  logic        RST,
    input  logic        enable,
    input  logic        force_resync,
    input  logic        pll_lck,
    input  logic        sync_ready,
    input  logic        code_err,
    output logic        rx_reset,
    output logic        link_up,
    output logic        fail,
    output logic [3:0]  retry_cnt,
    output logic [2:0]  state_dbg,
    output logic [7:0]  resync_count,
    output logic [15:0] err_total
);

    localparam int RST_W = cnt_w(RST_CYCLES);
    localparam int TO_W  = cnt_w(SYNC_TIMEOUT);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(SYNC_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RST_W-1:0]   RST_ONE   = RST_W'(1);
    localparam logic [TO_W-1:0]    TO_ONE    = TO_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

    sup_state_t         state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               rx_reset_q, link_up_q, fail_q;
    logic               limit_hit;
    logic               in_run;

    // Error window only observes the decoder while the link is up.
    rx_err_window #(
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_LIMIT  (ERR_LIMIT)
    ) u_err_window (
        .wclk        (wclk),
        .RST         (RST),
        .active_i    (state_q == ST_LOCKED),
        .code_err_i  (code_err),
        .limit_hit_o (limit_hit)
    );

    // States in which losing PLL lock forces a return to PLL_WAIT.
    assign in_run = (state_q == ST_RESET) || (state_q == ST_WAIT_SYNC) ||
                    (state_q == ST_LOCKED);

    // Next-state, reset/timeout counters and retry bookkeeping.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        retry_d   = retry_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_PLL_WAIT;
            end
            ST_PLL_WAIT: begin
                if (pll_lck) state_d = ST_RESET;
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_SYNC;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_ONE;
                end
            end
            ST_WAIT_SYNC: begin
                if (sync_ready) begin
                    state_d = ST_LOCKED;
                    retry_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_ONE;
                        state_d = ST_RESET;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            ST_LOCKED: begin
                if (!sync_ready || limit_hit) state_d = ST_RESET;
            end
            ST_FAIL: begin
                if (force_resync) begin
                    state_d = ST_PLL_WAIT;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Global overrides, highest priority first. A disabled channel
        // starts over, so its consecutive-timeout history is dropped.
        if (!enable) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else if (!pll_lck && in_run) begin
            state_d = ST_PLL_WAIT;
            retry_d = retry_q;
        end else if (force_resync &&
                     ((state_q == ST_WAIT_SYNC) || (state_q == ST_LOCKED))) begin
            state_d = ST_RESET;
            retry_d = retry_q;
        end

        // Every state entry starts its dwell counters from zero.
        if (state_d != state_q) begin
            rst_cnt_d = '0;
            to_cnt_d  = '0;
        end
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge wclk) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rst_cnt_q  <= '0;
            to_cnt_q   <= '0;
            retry_q    <= '0;
            rx_reset_q <= 1'b1;
            link_up_q  <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            to_cnt_q   <= to_cnt_d;
            retry_q    <= retry_d;
            rx_reset_q <= !((state_d == ST_WAIT_SYNC) || (state_d == ST_LOCKED));
            link_up_q  <= (state_d == ST_LOCKED);
            fail_q     <= (state_d == ST_FAIL);
        end
    end

    assign rx_reset  = rx_reset_q;
    assign link_up   = link_up_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state_dbg = state_q;

`ifdef RX_SUP_STATS_EN
    logic [RESYNC_W-1:0]    resync_q;
    logic [ERR_TOTAL_W-1:0] err_total_q;
    logic                   resync_evt;
    logic                   err_evt;

    // A resync is any entry into RESET from an aligned/aligning state;
    // the initial bring-up from PLL_WAIT is not counted.
    assign resync_evt = (state_d == ST_RESET) &&
                        ((state_q == ST_WAIT_SYNC) || (state_q == ST_LOCKED));
    assign err_evt    = (state_q == ST_LOCKED) && code_err;

    // Saturating statistics counters.
    always_ff @(posedge wclk) begin
        if (RST) begin
            resync_q    <= '0;
            err_total_q <= '0;
        end else begin
            if (resync_evt && (resync_q != {RESYNC_W{1'b1}})) begin
                resync_q <= resync_q + RESYNC_W'(1);
            end
            if (err_evt && (err_total_q != {ERR_TOTAL_W{1'b1}})) begin
                err_total_q <= err_total_q + ERR_TOTAL_W'(1);
            end
        end
    end

    assign resync_count = resync_q;
    assign err_total    = err_total_q;
`else
    assign resync_count = '0;
    assign err_total    = '0;
`endif

endmodule

// File: doc/rx_sync_supervisor.md
# rx_sync_supervisor

Per-channel link supervisor for the FE-I4 receive front end. It sequences the `rec_sync` reset and bring-up, bounds the wait for K28.1 word alignment with a timeout, and retries a bounded number of times. Once the link is up it watches decoder code errors and loss of sync/lock, and re-arms alignment when either occurs. It sits between the channel's `rec_sync` instance and the 8b10b decoder/status registers, one instance per receive channel.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `rx_reset` is held high per reset pulse (≥2).
- `SYNC_TIMEOUT`, 4096: cycles allowed in WAIT_SYNC before a retry.
- `ERR_WINDOW`, 1024: length in cycles of the code-error observation window.
- `ERR_LIMIT`, 8: code errors within one window that force a resync (≥1).
- `MAX_RETRY`, 15: consecutive timeouts tolerated before FAIL.

Ports:
- `wclk`, in, 1: word clock.
- `RST`, in, 1: synchronous, active-high reset; clock `wclk`.
- `enable`, in, 1: channel enable.
- `force_resync`, in, 1: single-cycle request to restart alignment.
- `pll_lck`, in, 1: receiver PLL lock.
- `sync_ready`, in, 1: `rec_sync` ready (sticky until its reset).
- `code_err`, in, 1: decoder code/disparity error strobe, one per bad word.
- `rx_reset`, out, 1: reset to `rec_sync`.
- `link_up`, out, 1: link aligned and healthy.
- `fail`, out, 1: retries exhausted.
- `retry_cnt`, out, 4: current consecutive timeout count.
- `state_dbg`, out, 3: state encoding.
- `resync_count`, out, 8: total resyncs since RST (see Configuration).
- `err_total`, out, 16: total code errors since RST (see Configuration).

## Operation
- States: IDLE, PLL_WAIT, RESET, WAIT_SYNC, LOCKED, FAIL.
- IDLE:
  - `rx_reset` = 1.
  - `enable` = 1 → PLL_WAIT.
- PLL_WAIT:
  - `rx_reset` = 1.
  - `pll_lck` = 1 → RESET.
- RESET:
  - `rx_reset` = 1 for exactly `RST_CYCLES` cycles → WAIT_SYNC.
- WAIT_SYNC:
  - `rx_reset` = 0; timeout counter runs.
  - `sync_ready` = 1 → LOCKED, `retry_cnt` ← 0.
  - Counter reaches `SYNC_TIMEOUT`−1 without `sync_ready`:
    - if `retry_cnt` == `MAX_RETRY` → FAIL;
    - otherwise `retry_cnt`++ → RESET.
- LOCKED:
  - `link_up` = 1; window counter and error counter run.
  - `sync_ready` = 0 → RESET.
  - Error count reaches `ERR_LIMIT` → RESET on the same cycle the limit is hit.
  - At window end, the error counter clears to 0, or to 1 if `code_err` is asserted on that cycle.
- FAIL:
  - `rx_reset` = 1, `fail` = 1.
  - Exits to PLL_WAIT only on `force_resync`; `retry_cnt` ← 0.
- Global priorities, highest first: `enable` = 0 → IDLE; then `pll_lck` = 0 in RESET/WAIT_SYNC/LOCKED → PLL_WAIT; then `force_resync` in WAIT_SYNC/LOCKED → RESET.
- `force_resync` in IDLE or PLL_WAIT is ignored.
- Each entry into RESET from WAIT_SYNC, LOCKED or `force_resync` counts as one resync; the PLL_WAIT→RESET transition does not.
- Counters saturate: `resync_count` at 255, `err_total` at 65535.
- `code_err` is counted only in LOCKED.

## Timing
- All outputs are registered and reflect the current state; no combinational input-to-output paths.
- Reset values: state IDLE, `rx_reset` 1, `link_up` 0, `fail` 0, `retry_cnt` 0, `resync_count` 0, `err_total` 0, `state_dbg` 0.
- Input-to-output latency is 1 cycle: `sync_ready` rising in WAIT_SYNC gives `link_up` = 1 on the next edge.
- `rx_reset` high time per pulse is exactly `RST_CYCLES` cycles when entering from WAIT_SYNC/LOCKED.
- `RST` mid-operation returns every register to its reset value on the next edge, regardless of state.

## Configuration
- `RX_SUP_STATS_EN` defined: the `resync_count` and `err_total` counters are implemented.
- `RX_SUP_STATS_EN` undefined: both outputs are tied to 0 and no counter logic is synthesized. The FSM is identical in both builds.

## Structure
- Shared package `rx_sup_pkg`:
  - state enum/localparams (IDLE=0, PLL_WAIT=1, RESET=2, WAIT_SYNC=3, LOCKED=4, FAIL=5);
  - counter width function (clog2).
- One sub-module `rx_err_window`: the window counter plus error counter, with a limit-hit strobe output.
- The FSM, the timeout counter and the statistics counters remain in the top level.

## Test plan
- RST, then `enable` = 1 with `pll_lck` = 1, and `sync_ready` = 1 at 100 cycles after `rx_reset` falls → `rx_reset` high for 16 cycles; `link_up` = 1 one cycle later; `retry_cnt` = 0.
- `sync_ready` held 0 → 16 timeouts, then FAIL with `fail` = 1 and `retry_cnt` = 15; a `force_resync` pulse → PLL_WAIT, `fail` = 0.
- In LOCKED, 8 `code_err` pulses within 1024 cycles → RESET on the 8th; `resync_count` = 1.
- In LOCKED, 7 errors per window across several windows → no resync; `err_total` accumulates; an error on the window-end cycle carries into the next window.
- `pll_lck` dropped in LOCKED → PLL_WAIT, `link_up` = 0 next cycle; restoring `pll_lck` → RESET 16 cycles, then WAIT_SYNC.
- `enable` = 0 and `force_resync` asserted on the same cycle → IDLE; `resync_count` unchanged. With the macro undefined → `resync_count` and `err_total` read 0 throughout.
